// File: rtl/beta_bm_feeder.sv
// beta_bm_feeder: computes branch metrics per step, buffers a frame and replays it in reverse with a state2 strobe and initial betas (TERMINATED_INIT_EN selects terminated-trellis init)
module beta_bm_feeder #(
  parameter int LLR_W     = 8,
  parameter int BLK_LEN   = 64,
  parameter int BM_OFFSET = 512,
  parameter int INIT_BIAS = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  input  logic signed [LLR_W-1:0] sys,
  input  logic signed [LLR_W-1:0] par,
  input  logic signed [LLR_W-1:0] apr,
  output logic                    state2,
  output logic [15:0]             old0,
  output logic [15:0]             old1,
  output logic [15:0]             old2,
  output logic [15:0]             old3,
  output logic [15:0]             old4,
  output logic [15:0]             old5,
  output logic [15:0]             old6,
  output logic [15:0]             old7,
  output logic [15:0]             m00,
  output logic [15:0]             m01,
  output logic [15:0]             m10,
  output logic [15:0]             m11,
  output logic                    out_valid,
  output logic                    out_last,
  output logic                    busy
);
  localparam int AW = BLK_LEN > 1 ? $clog2(BLK_LEN) : 1;
`ifdef TERMINATED_INIT_EN
  localparam logic [7:0][15:0] INIT_V = {{7{16'(INIT_BIAS)}}, 16'd0};
`else
  localparam logic [7:0][15:0] INIT_V = '0;
`endif
  typedef enum logic [1:0] {IDLE, FILL, LOAD, DRAIN} state_e;
  state_e            state_q;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [63:0]       mem [BLK_LEN];
  logic [63:0]       bm_d, m_q;
  logic [7:0][15:0]  old_q;
  logic signed [31:0] s_d;
  logic              last_wr_d;
  function automatic logic [15:0] clamp(input logic signed [31:0] v);
    return v < 0 ? 16'd0 : v > 65535 ? 16'hffff : v[15:0];
  endfunction
  always_comb begin
    s_d = 32'(sys) + 32'(apr);
    bm_d = {clamp(BM_OFFSET), clamp(BM_OFFSET + 32'(par)), clamp(BM_OFFSET + s_d),
            clamp(BM_OFFSET + s_d + 32'(par))};
    last_wr_d = in_last || wr_ptr_q == AW'(BLK_LEN - 1);
  end
  always_ff @(posedge clk)
    if (!rst && in_valid && in_ready) mem[wr_ptr_q] <= bm_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      in_ready  <= 1'b1;
      state2    <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      old_q     <= '0;
      m_q       <= '0;
    end else begin
      state2 <= 1'b0;
      case (state_q)
        IDLE, FILL: if (in_valid) begin
          if (last_wr_d) begin
            state_q  <= LOAD;
            state2   <= 1'b1;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            old_q    <= INIT_V;
          end else begin
            state_q  <= FILL;
            wr_ptr_q <= wr_ptr_q + 1'b1;
          end
        end
        LOAD: begin
          m_q       <= mem[wr_ptr_q];
          out_valid <= 1'b1;
          out_last  <= wr_ptr_q == '0;
          rd_ptr_q  <= wr_ptr_q - 1'b1;
          state_q   <= DRAIN;
        end
        DRAIN: if (out_last) begin
          state_q   <= IDLE;
          wr_ptr_q  <= '0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end else begin
          m_q      <= mem[rd_ptr_q];
          out_last <= rd_ptr_q == '0;
          rd_ptr_q <= rd_ptr_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign {m00, m01, m10, m11} = m_q;
  assign {old7, old6, old5, old4, old3, old2, old1, old0} = old_q;
endmodule

// File: tb/tb_beta_bm_feeder.sv
// tb_beta_bm_feeder: directed checks of metric values, reverse replay, truncation, reset and init betas
module tb_beta_bm_feeder;
`ifdef TERMINATED_INIT_EN
  localparam int BIAS = 256;
`else
  localparam int BIAS = 0;
`endif
  logic clk = 0, rst, in_valid, in_last;
  logic signed [7:0] sys, par, apr;
  logic in_ready, state2, out_valid, out_last, busy;
  logic [15:0] old [8];
  logic [15:0] m00, m01, m10, m11;
  logic c_in_ready, c_state2, c_out_valid, c_out_last, c_busy;
  logic [15:0] c_old [8];
  logic [15:0] c_m00, c_m01, c_m10, c_m11;
  int n_chk = 0, n_pass = 0;
  logic [15:0] q00[$], q01[$], q10[$], q11[$], qc10[$], qc11[$];
  bit ql[$];
  int first_idx, bad;
  bit rdy_seen;
  always #5 clk = ~clk;
  beta_bm_feeder u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .sys(sys), .par(par), .apr(apr), .state2(state2),
    .old0(old[0]), .old1(old[1]), .old2(old[2]), .old3(old[3]),
    .old4(old[4]), .old5(old[5]), .old6(old[6]), .old7(old[7]),
    .m00(m00), .m01(m01), .m10(m10), .m11(m11),
    .out_valid(out_valid), .out_last(out_last), .busy(busy)
  );
  beta_bm_feeder #(.BM_OFFSET(0)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_ready(c_in_ready),
    .sys(sys), .par(par), .apr(apr), .state2(c_state2),
    .old0(c_old[0]), .old1(c_old[1]), .old2(c_old[2]), .old3(c_old[3]),
    .old4(c_old[4]), .old5(c_old[5]), .old6(c_old[6]), .old7(c_old[7]),
    .m00(c_m00), .m01(c_m01), .m10(c_m10), .m11(c_m11),
    .out_valid(c_out_valid), .out_last(c_out_last), .busy(c_busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask
  task automatic push(input int s, input int p, input int a, input bit last);
    sys = 8'(s); par = 8'(p); apr = 8'(a);
    in_valid = 1; in_last = last;
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask
  task automatic collect(input int budget);
    q00.delete(); q01.delete(); q10.delete(); q11.delete();
    qc10.delete(); qc11.delete(); ql.delete();
    first_idx = -1; rdy_seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        if (first_idx < 0) first_idx = i;
        q00.push_back(m00); q01.push_back(m01); q10.push_back(m10); q11.push_back(m11);
        qc10.push_back(c_m10); qc11.push_back(c_m11); ql.push_back(out_last);
        if (in_ready) rdy_seen = 1;
      end else if (q10.size() > 0) break;
    end
  endtask
  initial begin
    rst = 1; in_valid = 0; in_last = 0; sys = 0; par = 0; apr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_state2", state2, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m11", m11, 0);
    chk("rst_old1", old[1], 0);
    rst = 0;
    for (int i = 1; i <= 4; i++) push(i, 0, 0, i == 4);
    chk("t1_state2", state2, 1);
    chk("t1_in_ready", in_ready, 0);
    chk("t1_busy", busy, 1);
    chk("t1_load_valid", out_valid, 0);
    chk("t1_old0", old[0], 0);
    for (int k = 1; k < 8; k++) chk($sformatf("t1_old%0d", k), old[k], BIAS);
    collect(20);
    chk("t1_count", q10.size(), 4);
    chk("t1_latency", first_idx, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t1_m10_%0d", k), q10[k], 516 - k);
      chk($sformatf("t1_last_%0d", k), ql[k], k == 3);
    end
    chk("t1_idle_ready", in_ready, 1);
    chk("t1_idle_state2", state2, 0);
    chk("t1_m10_hold", m10, 513);
    push(127, 127, 127, 1);
    chk("t2_state2", state2, 1);
    collect(10);
    chk("t2_count", q11.size(), 1);
    chk("t2_m11", q11[0], 893);
    chk("t2_m01", q01[0], 639);
    chk("t2_m00", q00[0], 512);
    chk("t2_m10", q10[0], 766);
    chk("t2_last", ql[0], 1);
    chk("t2_c_m11", qc11[0], 381);
    push(-128, -128, -128, 1);
    collect(10);
    chk("t2n_m11", q11[0], 128);
    chk("t2n_m10", q10[0], 256);
    chk("t2n_m01", q01[0], 384);
    chk("t2n_c_m11_clamp", qc11[0], 0);
    chk("t2n_c_m10_clamp", qc10[0], 0);
    in_valid = 1; in_last = 0; par = 0; apr = 0;
    for (int i = 0; i < 64; i++) begin
      sys = 8'(i);
      @(posedge clk); #1;
      if (i == 62) chk("t3_no_early_load", state2, 0);
    end
    chk("t3_state2", state2, 1);
    sys = 99;
    collect(80);
    in_valid = 0;
    chk("t3_count", q10.size(), 64);
    bad = 0;
    for (int k = 0; k < 64; k++) if (q10[k] !== 16'(575 - k)) bad++;
    chk("t3_order_bad", bad, 0);
    chk("t3_last", ql[63], 1);
    chk("t3_ready_low", rdy_seen, 0);
    chk("t3_idle_ready", in_ready, 1);
    for (int i = 0; i < 20; i++) push(i, 0, 0, i == 19);
    chk("t4_state2", state2, 1);
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("t4_mid_valid", out_valid, 1);
    chk("t4_mid_m10", m10, 522);
    rst = 1;
    @(posedge clk); #1;
    chk("t4_rst_valid", out_valid, 0);
    chk("t4_rst_state2", state2, 0);
    chk("t4_rst_ready", in_ready, 1);
    chk("t4_rst_busy", busy, 0);
    rst = 0;
    push(10, 1, 0, 0);
    push(20, 1, 0, 0);
    push(30, 1, 0, 1);
    chk("t4_state2_new", state2, 1);
    collect(10);
    chk("t4_count", q10.size(), 3);
    chk("t4_m10_0", q10[0], 542);
    chk("t4_m11_0", q11[0], 543);
    chk("t4_m10_1", q10[1], 532);
    chk("t4_m10_2", q10[2], 522);
    chk("t4_last_0", ql[0], 0);
    chk("t4_last_2", ql[2], 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
